up_cnt: RTL

UP_CNT -- requirements
Module: up_cnt

---
 rtl/up_cnt.sv | 98 +++++++++
 1 files changed

// File: rtl/up_cnt.sv
// rtl/up_cnt.sv - 4-bit up counter with IDLE/RUN/DONE sequencing; UP_CNT_AUTORELOAD_EN selects auto-reload
module up_cnt (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       stop,
  input  logic       en,
  input  logic [3:0] limit,
  output logic [3:0] Q,
  output logic       busy,
  output logic       done,
  output logic       tc
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] q_nxt;
  logic [3:0] lim_r;
  logic [3:0] lim_nxt;
  logic       tc_nxt;

  // Next-state, next-count and terminal pulse; stop outranks start, start outranks en.
  always_comb begin
    state_nxt = state;
    q_nxt     = Q;
    lim_nxt   = lim_r;
    tc_nxt    = 1'b0;
    case (state)
      IDLE: begin
        q_nxt = 4'd0;
        if (!stop && start) begin
          state_nxt = RUN;
          lim_nxt   = limit;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
          q_nxt     = 4'd0;
        end else if (start) begin
          q_nxt   = 4'd0;
          lim_nxt = limit;
        end else if (en) begin
          if (Q != lim_r) begin
            q_nxt = Q + 4'd1;
          end else begin
            tc_nxt = 1'b1;
`ifdef UP_CNT_AUTORELOAD_EN
            q_nxt  = 4'd0;
`else
            state_nxt = DONE;
`endif
          end
        end
      end
      DONE: begin
        if (stop) begin
          state_nxt = IDLE;
          q_nxt     = 4'd0;
        end else if (start) begin
          state_nxt = RUN;
          q_nxt     = 4'd0;
          lim_nxt   = limit;
        end
      end
      default: begin
        state_nxt = IDLE;
        q_nxt     = 4'd0;
      end
    endcase
  end

  // State, count, captured limit and registered status flags; clr dominates everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      Q     <= 4'd0;
      lim_r <= 4'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      Q     <= q_nxt;
      lim_r <= lim_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
      tc    <= tc_nxt;
    end
  end

endmodule
